// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the multi-port register file.
//   REGFILE_DATA_W / _DEPTH / _NUM_RD / _NUM_WR : default parameter values
//   lanes(data_w)      : number of byte lanes in a data_w-bit word
//   addr_valid(a, d)   : 1 when address a may hold data in a depth-d file
// Optional feature macro: REGFILE_R0_ZERO_EN (register 0 hardwired to zero).
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int REGFILE_DATA_W = 64;
    localparam int REGFILE_DEPTH  = 32;
    localparam int REGFILE_NUM_RD = 2;
    localparam int REGFILE_NUM_WR = 2;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

    // An address is usable when it is inside the array and, with the
    // zero-register option, is not register 0. Invalid addresses never
    // store, never reserve and always read as zero / not busy.
    function automatic logic addr_valid(input int addr, input int depth);
        logic ok;
        ok = (addr < depth);
`ifdef REGFILE_R0_ZERO_EN
        if (addr == 0) begin
            ok = 1'b0;
        end
`endif
        return ok;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of regfile_mp: address decode, lane-wise
// write-first bypass from all write ports and busy lookup.
// Ports:
//   rd_addr   in  ADDR_W           register to read
//   mem_flat  in  DEPTH*DATA_W     stored array contents, register r at slice r
//   busy_vec  in  DEPTH            stored busy bits
//   bypass_en in  1                0 suppresses bypass (reset cycle)
//   wr_en     in  NUM_WR           write enables
//   wr_addr   in  NUM_WR*ADDR_W    write addresses
//   wr_data   in  NUM_WR*DATA_W    write data
//   wr_mask   in  NUM_WR*LANES     byte-lane enables
//   rd_data   out DATA_W           read data
//   rd_busy   out 1                busy bit of rd_addr
// Optional feature macro: REGFILE_R0_ZERO_EN (via regfile_pkg::addr_valid).
// ---------------------------------------------------------------------------
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_WR = REGFILE_NUM_WR,
    parameter int LANES  = lanes(DATA_W)
) (
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DEPTH*DATA_W-1:0]  mem_flat,
    input  logic [DEPTH-1:0]         busy_vec,
    input  logic                     bypass_en,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR*LANES-1:0]  wr_mask,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_busy
);

    logic rd_valid;

    assign rd_valid = addr_valid(int'(rd_addr), DEPTH);

    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        // Decode against real registers only; an out-of-range address
        // simply matches nothing and stays zero.
        for (int r = 0; r < DEPTH; r++) begin
            if (rd_valid && (rd_addr == ADDR_W'(r))) begin
                rd_data = mem_flat[r*DATA_W +: DATA_W];
                rd_busy = busy_vec[r];
            end
        end
        // Ascending port order: later assignments win, so the highest
        // matching port owns each lane, exactly as in the commit logic.
        if (bypass_en && rd_valid) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == rd_addr)) begin
                    for (int b = 0; b < LANES; b++) begin
                        if (wr_mask[i*LANES + b]) begin
                            rd_data[b*8 +: 8] = wr_data[i*DATA_W + b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with byte-lane write masks,
// same-cycle write-to-read bypass and a per-register busy scoreboard.
// Ports:
//   clk      in  1               rising-edge clock
//   reset    in  1               synchronous active-high reset
//   wr_en    in  NUM_WR          per-port write enable
//   wr_addr  in  NUM_WR*ADDR_W   write addresses, port i in slice i
//   wr_data  in  NUM_WR*DATA_W   write data
//   wr_mask  in  NUM_WR*DATA_W/8 byte-lane enables, bit 0 = bits 7:0
//   rsv_en   in  1               reserve rsv_addr (set busy)
//   rsv_addr in  ADDR_W          register to reserve
//   rd_addr  in  NUM_RD*ADDR_W   read addresses
//   rd_data  out NUM_RD*DATA_W   read data (combinational, write-first)
//   rd_busy  out NUM_RD          registered busy bit of each read address
// Optional feature macro: REGFILE_R0_ZERO_EN -- register 0 reads zero,
// ignores writes and reservations.
// ---------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = REGFILE_NUM_RD,
    parameter int NUM_WR = REGFILE_NUM_WR
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]       wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]       wr_data,
    input  logic [NUM_WR*lanes(DATA_W)-1:0] wr_mask,
    input  logic                           rsv_en,
    input  logic [ADDR_W-1:0]              rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0]       rd_addr,
    output logic [NUM_RD*DATA_W-1:0]       rd_data,
    output logic [NUM_RD-1:0]              rd_busy
);

    localparam int LANES = lanes(DATA_W);

    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DATA_W-1:0]       mem_d [DEPTH];
    logic [DEPTH-1:0]        busy_q;
    logic [DEPTH-1:0]        busy_d;
    logic [DEPTH*DATA_W-1:0] mem_flat;

    // Next-state for array and scoreboard.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        // Ascending port order gives the highest-index port lane priority.
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && addr_valid(int'(wr_addr[i*ADDR_W +: ADDR_W]), DEPTH)) begin
                for (int b = 0; b < LANES; b++) begin
                    if (wr_mask[i*LANES + b]) begin
                        mem_d[wr_addr[i*ADDR_W +: ADDR_W]][b*8 +: 8] =
                            wr_data[i*DATA_W + b*8 +: 8];
                    end
                end
                // Completion clears busy even when the mask writes nothing.
                busy_d[wr_addr[i*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        // Reservation is applied last so a new producer beats a
        // same-cycle completion on the same register.
        if (rsv_en && addr_valid(int'(rsv_addr), DEPTH)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign mem_flat[gi*DATA_W +: DATA_W] = mem_q[gi];
        end

        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            regfile_read_port #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .ADDR_W (ADDR_W),
                .NUM_WR (NUM_WR),
                .LANES  (LANES)
            ) u_rd (
                .rd_addr   (rd_addr[gi*ADDR_W +: ADDR_W]),
                .mem_flat  (mem_flat),
                .busy_vec  (busy_q),
                .bypass_en (!reset),
                .wr_en     (wr_en),
                .wr_addr   (wr_addr),
                .wr_data   (wr_data),
                .wr_mask   (wr_mask),
                .rd_data   (rd_data[gi*DATA_W +: DATA_W]),
                .rd_busy   (rd_busy[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Directed test of regfile_mp with default parameters (64-bit, 32 regs,
// 2 read / 2 write ports). Inputs change 1 ns after the rising edge and
// outputs are checked 1 ns later, well away from the next edge.
// Optional feature macro: REGFILE_R0_ZERO_EN changes the R0 expectations.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NL = 8;

    logic            clk;
    logic            reset;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [2*NL-1:0] wr_mask;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]      rd_busy;

    int n_vec = 0;
    int n_err = 0;

    regfile_mp dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_mask  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NL-1:0] m);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
        wr_mask[p*NL +: NL] = m;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        set_rd(5'd0, 5'd0);
        repeat (3) tick();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            set_rd(AW'(a), AW'(31 - a));
            #1;
            n_vec++;
            if (rd_data !== '0 || rd_busy !== 2'b00) begin
                n_err++;
                $display("FAIL reset_clear addr=%0d/%0d got data=%h busy=%b want 0/00",
                         a, 31 - a, rd_data, rd_busy);
            end
        end
    endtask

    task automatic test_write_bypass();
        idle();
        set_wr(0, 5'd1, 64'h200200000000FA50, 8'hFF);
        set_rd(5'd1, 5'd2);
        #1;
        n_vec++;
        if (rd_data[DW-1:0] !== 64'h200200000000FA50) begin
            n_err++;
            $display("FAIL bypass_r1 got %h want %h", rd_data[DW-1:0], 64'h200200000000FA50);
        end
        tick();
        idle();
        set_wr(0, 5'd2, 64'h0002000000006840, 8'hFF);
        set_rd(5'd2, 5'd1);
        #1;
        n_vec++;
        if (rd_data !== {64'h200200000000FA50, 64'h0002000000006840}) begin
            n_err++;
            $display("FAIL bypass_r2 got %h want %h", rd_data,
                     {64'h200200000000FA50, 64'h0002000000006840});
        end
        tick();
        idle();
        set_rd(5'd1, 5'd2);
        #1;
        n_vec++;
        if (rd_data !== {64'h0002000000006840, 64'h200200000000FA50}) begin
            n_err++;
            $display("FAIL stored_r1_r2 got %h want %h", rd_data,
                     {64'h0002000000006840, 64'h200200000000FA50});
        end
    endtask

    task automatic test_lane_priority();
        idle();
        set_wr(0, 5'd5, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        set_wr(1, 5'd5, 64'h0, 8'h0F);
        set_rd(5'd5, 5'd5);
        #1;
        n_vec++;
        if (rd_data !== {2{64'hFFFFFFFF00000000}}) begin
            n_err++;
            $display("FAIL prio_bypass got %h want %h", rd_data, {2{64'hFFFFFFFF00000000}});
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (rd_data[DW-1:0] !== 64'hFFFFFFFF00000000) begin
            n_err++;
            $display("FAIL prio_stored got %h want %h", rd_data[DW-1:0], 64'hFFFFFFFF00000000);
        end
        // Single-lane write on port 1 plus an all-zero-mask write on port 0.
        set_wr(1, 5'd5, 64'h1111111111111111, 8'h01);
        set_wr(0, 5'd5, 64'h2222222222222222, 8'h00);
        tick();
        idle();
        #1;
        n_vec++;
        if (rd_data[DW-1:0] !== 64'hFFFFFFFF00000011) begin
            n_err++;
            $display("FAIL lane_partial got %h want %h", rd_data[DW-1:0], 64'hFFFFFFFF00000011);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en   = 1'b1;
        rsv_addr = 5'd7;
        set_rd(5'd7, 5'd9);
        #1;
        n_vec++;
        if (rd_busy !== 2'b00) begin
            n_err++;
            $display("FAIL rsv_no_bypass got busy=%b want 00", rd_busy);
        end
        tick();
        idle();
        set_wr(1, 5'd7, 64'h7, 8'hFF);
        #1;
        n_vec++;
        if (rd_busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rsv_visible got busy=%b want 1", rd_busy[0]);
        end
        tick();
        idle();
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        set_wr(0, 5'd9, 64'h9, 8'hFF);
        #1;
        n_vec++;
        if (rd_busy !== 2'b00 || rd_data[DW-1:0] !== 64'h7) begin
            n_err++;
            $display("FAIL wr_clear got busy=%b data=%h want 00/7", rd_busy, rd_data[DW-1:0]);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (rd_busy !== 2'b10 || rd_data[2*DW-1:DW] !== 64'h9) begin
            n_err++;
            $display("FAIL rsv_wins got busy=%b data=%h want 10/9", rd_busy, rd_data[2*DW-1:DW]);
        end
        // Zero-mask write still completes the producer.
        set_wr(0, 5'd9, 64'hABCD, 8'h00);
        tick();
        idle();
        #1;
        n_vec++;
        if (rd_busy[1] !== 1'b0 || rd_data[2*DW-1:DW] !== 64'h9) begin
            n_err++;
            $display("FAIL zero_mask_clear got busy=%b data=%h want 0/9",
                     rd_busy[1], rd_data[2*DW-1:DW]);
        end
    endtask

    task automatic test_reset_midstream();
        idle();
        rsv_en   = 1'b1;
        rsv_addr = 5'd7;
        set_wr(0, 5'd3, 64'h3333, 8'hFF);
        tick();
        idle();
        reset = 1'b1;
        set_wr(0, 5'd3, 64'h4444, 8'hFF);
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        set_rd(5'd3, 5'd7);
        #1;
        n_vec++;
        if (rd_data[DW-1:0] !== 64'h3333 || rd_busy !== 2'b10) begin
            n_err++;
            $display("FAIL reset_cycle_view got data=%h busy=%b want 3333/10",
                     rd_data[DW-1:0], rd_busy);
        end
        tick();
        reset = 1'b0;
        idle();
        #1;
        n_vec++;
        if (rd_data !== '0 || rd_busy !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mid got data=%h busy=%b want 0/00", rd_data, rd_busy);
        end
        set_rd(5'd9, 5'd1);
        #1;
        n_vec++;
        if (rd_data !== '0 || rd_busy !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ignores_rsv got data=%h busy=%b want 0/00", rd_data, rd_busy);
        end
    endtask

    task automatic test_r0();
        logic [DW-1:0] exp_d;
        logic          exp_b;
`ifdef REGFILE_R0_ZERO_EN
        exp_d = 64'h0;
        exp_b = 1'b0;
`else
        exp_d = 64'hDEADBEEF;
        exp_b = 1'b1;
`endif
        idle();
        set_wr(0, 5'd0, 64'hDEADBEEF, 8'hFF);
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        #1;
        n_vec++;
        if (rd_data[DW-1:0] !== exp_d) begin
            n_err++;
            $display("FAIL r0_bypass got %h want %h", rd_data[DW-1:0], exp_d);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (rd_data[2*DW-1:DW] !== exp_d || rd_busy[1] !== exp_b) begin
            n_err++;
            $display("FAIL r0_stored got data=%h busy=%b want %h/%b",
                     rd_data[2*DW-1:DW], rd_busy[1], exp_d, exp_b);
        end
    endtask

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        idle();
        test_reset();
        test_write_bypass();
        test_lane_priority();
        test_scoreboard();
        test_reset_midstream();
        test_r0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the 64-bit CPU core of the mesh NoC node; successor to the single-write, two-read `register_file`. Adds:
- configurable read and write port counts, width and depth;
- byte-lane write masks;
- same-cycle write-to-read bypass;
- a per-register busy scoreboard that issue logic uses to stall on pending producers.

It sits between decode/issue (reads, reservations) and writeback (writes, which may come from the ALU and NIC paths).

## Interface
Parameters:
- `DATA_W`, 64, register width in bits; must be a multiple of 8.
- `DEPTH`, 32, number of registers.
- `ADDR_W`, $clog2(DEPTH), register address width.
- `NUM_RD`, 2, read ports.
- `NUM_WR`, 2, write ports.

Ports:
- `clk`  in  1  clock. One clock; everything is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  NUM_WR  per-port write enable.
- `wr_addr`  in  NUM_WR*ADDR_W  write addresses; port i uses slice i.
- `wr_data`  in  NUM_WR*DATA_W  write data.
- `wr_mask`  in  NUM_WR*(DATA_W/8)  byte-lane enables; bit 0 selects bits 7:0.
- `rsv_en`  in  1  reserve: mark `rsv_addr` busy.
- `rsv_addr`  in  ADDR_W  register to reserve.
- `rd_addr`  in  NUM_RD*ADDR_W  read addresses.
- `rd_data`  out  NUM_RD*DATA_W  read data, combinational.
- `rd_busy`  out  NUM_RD  busy bit of the addressed register, combinational.

## Operation
Write commit:
- At each rising edge, every lane b of register r takes the data of the highest-index write port i with `wr_en[i]`, `wr_addr[i]==r` and `wr_mask[i][b]` all set.
- Lanes that no port selects hold their value.
- A port with `wr_en` set but an all-zero mask writes no data. It still clears busy.
- Out-of-range addresses (when DEPTH < 2^ADDR_W): writes are dropped, reads return 0, busy reads 0.

Read:
- `rd_data[j]` is the stored value of `rd_addr[j]`, with each lane replaced by that lane's winning same-cycle write data when one exists. Reads are write-first.
- Reads never block.

Scoreboard, one busy bit per register:
- `rsv_en` sets `busy[rsv_addr]` at the edge.
- Any `wr_en[i]` to an address clears its busy bit at the edge.
- Reserve and write to the same register in the same cycle: busy ends set (the new producer wins); the data is still written.
- `rd_busy[j]` is the registered busy bit. There is no bypass: a reservation becomes visible the cycle after `rsv_en`, and a clear becomes visible the cycle after the write.

Reset:
- All registers go to 0 and all busy bits go to 0 at the edge where `reset` is high.
- Writes and reservations in that cycle are ignored.
- While `reset` is high, `rd_data` shows the array contents with no bypass, and `rd_busy` shows the stored bits.
- The first cycle after reset deasserts reads 0 everywhere.

## Timing
- Write latency 1 cycle to the array; 0 cycles to readers via bypass.
- Reserve-to-busy latency 1 cycle; write-to-not-busy latency 1 cycle.
- Critical path: write data → lane priority mux → read bypass mux → `rd_data`. Keep NUM_WR ≤ 4.

## Configuration
- `REGFILE_R0_ZERO_EN` defined:
  - register 0 is hardwired to zero;
  - writes to address 0 are discarded, including from bypass;
  - reservations of address 0 are ignored;
  - reads of address 0 return data 0, busy 0.
- Not defined: register 0 is an ordinary register.

## Structure
- Package `regfile_pkg` holds:
  - the default constants (`REGFILE_DATA_W`, `REGFILE_DEPTH`, `REGFILE_NUM_RD`, `REGFILE_NUM_WR`);
  - the function `lanes(DATA_W)` returning DATA_W/8.
- Sub-module `regfile_read_port`, instantiated NUM_RD times. It does the per-port address decode, lane-wise bypass from all write ports using the same priority rule as commit, and busy lookup.
- The top level holds the array, the write commit logic and the scoreboard.

## Test plan
- Reset for 3 cycles; read addresses 0–31 on both ports → data 0, busy 0.
- Port 0 writes R1=64'h200200000000FA50 mask 8'hFF; next cycle port 0 writes R2=64'h0002000000006840. Then read R1/R2 → exact values. During each write cycle, a read of the same address returns the new value (bypass).
- Same cycle: port 0 writes R5 = all-ones with mask 8'hFF; port 1 writes R5=64'h0 with mask 8'h0F → R5 = 64'hFFFFFFFF00000000. Bypass read in that cycle shows the same.
- Reserve R7 → `rd_busy` for R7 is 1 from the next cycle. Port 1 writes R7 → busy 0 the cycle after. Reserve and write R9 in the same cycle → busy 1.
- Assert `reset` mid-stream while a write to R3 is pending and R7 is reserved → R3=0, all busy 0. Write and reserve in the reset cycle are ignored.
- With `REGFILE_R0_ZERO_EN`: write R0=64'hDEADBEEF and reserve R0 → reads and bypass return 0, busy 0. Without the macro → R0 reads 64'hDEADBEEF and busy 1.
